// File: rtl/stage_id.sv
// MIPS instruction-decode stage: 32x32 register file, control decode, load-use stall, j/jal resolution, ID/EX register.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the operand reads.
module stage_id (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] iadd,
  input  logic        nop_in,
  input  logic        flush,
  input  logic        ex_mem_read_in,
  input  logic [4:0]  ex_rt_in,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        stall,
  output logic        control_is_jump,
  output logic [31:0] data_jump_address,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [5:0]  ex_funct,
  output logic [5:0]  ex_opcode,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_reg_dst,
  output logic        ex_branch_eq,
  output logic        ex_branch_ne,
  output logic        ex_link,
  output logic [31:0] ex_npc,
  output logic        nop_out
);
  // The hazard inputs carry an _in suffix because the ID/EX outputs already own ex_mem_read/ex_rt.
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic [31:0] r_regs [32];
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt;
  logic [31:0] w_rs_data, w_rt_data, w_imm;
  logic        w_valid, w_reg_write, w_mem_read, w_mem_write, w_alu_src, w_reg_dst;
  logic        w_beq, w_bne, w_link, w_is_jump, w_reads_rt, w_stall, w_bubble;
  logic [7:0]  r_ctl;
  logic        r_nop;
  logic [31:0] r_rs_data, r_rt_data, r_imm, r_npc;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [5:0]  r_funct, r_opcode;

  assign w_opcode = instruction[31:26];
  assign w_funct  = instruction[5:0];
  assign w_rs     = instruction[25:21];
  assign w_rt     = instruction[20:16];

`ifdef REGFILE_BYPASS_EN
  assign w_rs_data = (w_rs == 5'd0) ? 32'd0 :
                     (wb_reg_write && (wb_write_reg == w_rs)) ? wb_write_data : r_regs[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'd0 :
                     (wb_reg_write && (wb_write_reg == w_rt)) ? wb_write_data : r_regs[w_rt];
`else
  assign w_rs_data = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
`endif

  // Register file storage; r0 is never written and is masked on read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (wb_reg_write && (wb_write_reg != 5'd0)) begin
      r_regs[wb_write_reg] <= wb_write_data;
    end
  end

  // Control decode of the supported subset; anything else leaves w_valid low.
  always_comb begin
    w_valid = 1'b0; w_reg_write = 1'b0; w_mem_read = 1'b0; w_mem_write = 1'b0;
    w_alu_src = 1'b0; w_reg_dst = 1'b0; w_beq = 1'b0; w_bne = 1'b0; w_link = 1'b0;
    w_is_jump = 1'b0; w_reads_rt = 1'b0;
    w_imm = {{16{instruction[15]}}, instruction[15:0]};
    case (w_opcode)
      OP_RTYPE: begin
        w_reads_rt = 1'b1;
        case (w_funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: begin
            w_valid = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1;
          end
          F_JR:    w_valid = 1'b1;
          default: w_valid = 1'b0;
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        w_valid = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        w_valid = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
        w_imm = {16'h0000, instruction[15:0]};
      end
      OP_LUI: begin
        w_valid = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
        w_imm = {instruction[15:0], 16'h0000};
      end
      OP_LW: begin
        w_valid = 1'b1; w_reg_write = 1'b1; w_mem_read = 1'b1; w_alu_src = 1'b1;
      end
      OP_SW: begin
        w_valid = 1'b1; w_mem_write = 1'b1; w_alu_src = 1'b1; w_reads_rt = 1'b1;
      end
      OP_BEQ: begin
        w_valid = 1'b1; w_beq = 1'b1; w_reads_rt = 1'b1;
      end
      OP_BNE: begin
        w_valid = 1'b1; w_bne = 1'b1; w_reads_rt = 1'b1;
      end
      OP_J: begin
        w_valid = 1'b1; w_is_jump = 1'b1;
      end
      OP_JAL: begin
        w_valid = 1'b1; w_is_jump = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_link = 1'b1;
      end
      default: w_valid = 1'b0;
    endcase
  end

  assign w_stall = ex_mem_read_in & ~nop_in & (ex_rt_in != 5'd0) &
                   ((ex_rt_in == w_rs) | ((ex_rt_in == w_rt) & w_reads_rt));
  assign w_bubble = flush | w_stall | nop_in | ~w_valid;

  assign stall             = w_stall;
  assign control_is_jump   = w_is_jump & ~nop_in & ~flush & ~w_stall;
  assign data_jump_address = {iadd[31:28], instruction[25:0], 2'b00};

  // ID/EX pipeline register; a bubble clears control only, operand fields keep their last values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctl <= 8'd0; r_nop <= 1'b1;
      r_rs_data <= 32'd0; r_rt_data <= 32'd0; r_imm <= 32'd0; r_npc <= 32'd0;
      r_rs <= 5'd0; r_rt <= 5'd0; r_rd <= 5'd0; r_funct <= 6'd0; r_opcode <= 6'd0;
    end else if (w_bubble) begin
      r_ctl <= 8'd0; r_nop <= 1'b1;
    end else begin
      r_ctl <= {w_reg_write, w_mem_read, w_mem_write, w_alu_src, w_reg_dst, w_beq, w_bne, w_link};
      r_nop <= 1'b0;
      r_rs_data <= w_rs_data; r_rt_data <= w_rt_data; r_imm <= w_imm;
      r_npc <= iadd + 32'd4;
      r_rs <= w_rs; r_rt <= w_rt;
      r_rd <= (w_opcode == OP_JAL) ? 5'd31 : instruction[15:11];
      r_funct <= w_funct; r_opcode <= w_opcode;
    end
  end

  assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst,
          ex_branch_eq, ex_branch_ne, ex_link} = r_ctl;
  assign nop_out    = r_nop;
  assign ex_rs_data = r_rs_data;
  assign ex_rt_data = r_rt_data;
  assign ex_imm     = r_imm;
  assign ex_npc     = r_npc;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign ex_funct   = r_funct;
  assign ex_opcode  = r_opcode;
endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: directed scenarios plus random stimulus against a reference model.
module tb_stage_id;
  logic        clock = 1'b0;
  logic        reset, nop_in, flush, ex_mem_read_in, wb_reg_write;
  logic [31:0] instruction, iadd, wb_write_data;
  logic [4:0]  ex_rt_in, wb_write_reg;
  logic        stall, control_is_jump, nop_out;
  logic [31:0] data_jump_address, ex_rs_data, ex_rt_data, ex_imm, ex_npc;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct, ex_opcode;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
  logic        ex_branch_eq, ex_branch_ne, ex_link;

  always #5 clock = ~clock;

  stage_id dut (
    .clock(clock), .reset(reset), .instruction(instruction), .iadd(iadd),
    .nop_in(nop_in), .flush(flush), .ex_mem_read_in(ex_mem_read_in), .ex_rt_in(ex_rt_in),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .stall(stall), .control_is_jump(control_is_jump), .data_jump_address(data_jump_address),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_opcode(ex_opcode),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_branch_eq(ex_branch_eq),
    .ex_branch_ne(ex_branch_ne), .ex_link(ex_link), .ex_npc(ex_npc), .nop_out(nop_out)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed { logic [8:0] ctl; logic [154:0] dat; logic known; } exp_t;
  typedef struct packed {
    logic valid, rw, mr, mw, as, rdst, beq, bne, link, jump, reads_rt;
    logic [31:0] imm;
  } dec_t;

  exp_t        q[$];
  int          errors = 0, checks = 0;
  logic [31:0] m_regs [32];
  logic [8:0]  m_ctl;
  logic [154:0] m_dat;
  logic        m_known;
  bit          pending_release;
  logic [8:0]  d_ctl;
  logic [154:0] d_dat;
  logic [5:0]  op_tab [0:13] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  logic [5:0]  fn_tab [0:7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};

  assign d_ctl = {nop_out, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst,
                  ex_branch_eq, ex_branch_ne, ex_link};
  assign d_dat = {ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, ex_opcode, ex_npc};

  task automatic chk(input string name, input logic [154:0] got, input logic [154:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Instruction-level meaning of each supported opcode, straight from the ISA subset.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [5:0] op, fn;
    logic [15:0] im;
    op = ins[31:26]; fn = ins[5:0]; im = ins[15:0];
    d = '0;
    d.imm = {{16{im[15]}}, im};
    d.reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    case (op)
      6'h00: if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) begin
               d.valid = 1'b1; d.rw = 1'b1; d.rdst = 1'b1;
             end else if (fn == 6'h08) d.valid = 1'b1;
      6'h08, 6'h0A: begin d.valid = 1'b1; d.rw = 1'b1; d.as = 1'b1; end
      6'h0C, 6'h0D: begin d.valid = 1'b1; d.rw = 1'b1; d.as = 1'b1; d.imm = {16'h0000, im}; end
      6'h0F: begin d.valid = 1'b1; d.rw = 1'b1; d.as = 1'b1; d.imm = {im, 16'h0000}; end
      6'h23: begin d.valid = 1'b1; d.rw = 1'b1; d.mr = 1'b1; d.as = 1'b1; end
      6'h2B: begin d.valid = 1'b1; d.mw = 1'b1; d.as = 1'b1; end
      6'h04: begin d.valid = 1'b1; d.beq = 1'b1; end
      6'h05: begin d.valid = 1'b1; d.bne = 1'b1; end
      6'h02: begin d.valid = 1'b1; d.jump = 1'b1; end
      6'h03: begin d.valid = 1'b1; d.jump = 1'b1; d.rw = 1'b1; d.rdst = 1'b1; d.link = 1'b1; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we, input logic [4:0] wr,
                                           input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (BYP && we && (wr == r)) return wd;
    return m_regs[r];
  endfunction

  // One ID cycle: drive at negedge, check combinational outputs, queue the expected ID/EX state.
  task automatic step(input logic [31:0] ins, ia, input logic ni, fl, emr, input logic [4:0] ert,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    dec_t d;
    logic [4:0] rs, rt;
    logic st;
    exp_t e;
    @(negedge clock);
    if (pending_release) begin reset = 1'b0; pending_release = 1'b0; end
    instruction = ins; iadd = ia; nop_in = ni; flush = fl; ex_mem_read_in = emr; ex_rt_in = ert;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    #1;
    d = ref_decode(ins); rs = ins[25:21]; rt = ins[20:16];
    st = emr && !ni && (ert != 5'd0) && ((ert == rs) || ((ert == rt) && d.reads_rt));
    chk("stall", stall, st);
    chk("control_is_jump", control_is_jump, d.jump && !ni && !fl && !st);
    chk("data_jump_address", data_jump_address, {ia[31:28], ins[25:0], 2'b00});
    if (fl || st || ni || !d.valid) begin
      m_ctl = 9'h100;
      if (fl || !st) m_known = 1'b0;
    end else begin
      m_ctl = {1'b0, d.rw, d.mr, d.mw, d.as, d.rdst, d.beq, d.bne, d.link};
      m_dat = {ref_read(rs, we, wr, wd), ref_read(rt, we, wr, wd), d.imm, rs, rt,
               (ins[31:26] == 6'h03) ? 5'd31 : ins[15:11], ins[5:0], ins[31:26], ia + 32'd4};
      m_known = 1'b1;
    end
    e.ctl = m_ctl; e.dat = m_dat; e.known = m_known;
    q.push_back(e);
    if (we && (wr != 5'd0)) m_regs[wr] = wd;
  endtask

  task automatic idle(input logic we, input logic [4:0] wr, input logic [31:0] wd);
    step(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, we, wr, wd);
  endtask

  task automatic after_edge();
    @(posedge clock); #2;
  endtask

  task automatic model_reset();
    q.delete();
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_ctl = 9'h100; m_dat = '0; m_known = 1'b1;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1; nop_in = 1'b1; flush = 1'b0; ex_mem_read_in = 1'b0; wb_reg_write = 1'b0;
    #1;
    chk("rst_nop_out", nop_out, 1'b1);
    chk("rst_reg_write", ex_reg_write, 1'b0);
    chk("rst_ctl", d_ctl, 9'h100);
    chk("rst_data", d_dat, 155'd0);
    model_reset();
    @(posedge clock); #1;
    chk("rst_held", d_ctl, 9'h100);
    pending_release = 1'b1;
  endtask

  task automatic rand_step();
    logic [31:0] ins, ia, wd;
    logic [4:0] ert, wr;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 14);
    if (k < 14) ins[31:26] = op_tab[k];
    if (ins[31:26] == 6'h00) ins[5:0] = fn_tab[$urandom_range(0, 7)];
    case ($urandom_range(0, 3))
      0, 1:    ert = ins[25:21];
      2:       ert = ins[20:16];
      default: ert = 5'($urandom);
    endcase
    ia = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    wr = 5'($urandom); wd = $urandom;
    step(ins, ia, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 2,
         ert, $urandom_range(0, 1) == 1, wr, wd);
  endtask

  // Monitor: every edge the DUT presents a new ID/EX state; pop and compare it.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("idex_ctl", d_ctl, e.ctl);
        if (e.known) chk("idex_data", d_dat, e.dat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instruction = 32'd0; iadd = 32'd0; nop_in = 1'b1; flush = 1'b0;
    ex_mem_read_in = 1'b0; ex_rt_in = 5'd0; wb_reg_write = 1'b0; wb_write_reg = 5'd0;
    wb_write_data = 32'd0;
    model_reset();
    #1;
    chk("init_ctl", d_ctl, 9'h100);
    chk("init_data", d_dat, 155'd0);
    chk("init_stall", stall, 1'b0);
    pending_release = 1'b1;

    idle(1'b1, 5'd5, 32'h1234_5678);
    step(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h0040_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    after_edge();
    chk("add_rs_data", ex_rs_data, 32'h1234_5678);
    chk("add_rd", ex_rd, 5'd3);

    idle(1'b1, 5'd0, 32'hFFFF_FFFF);
    step(rtype(5'd0, 5'd0, 5'd1, 6'h20), 32'h0040_0004, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    after_edge();
    chk("r0_reads_zero", ex_rs_data, 32'd0);

    step(rtype(5'd8, 5'd9, 5'd2, 6'h20), 32'h0040_0008, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
    chk("loaduse_stall", stall, 1'b1);
    after_edge();
    chk("loaduse_bubble", nop_out, 1'b1);
    step(rtype(5'd8, 5'd9, 5'd2, 6'h20), 32'h0040_0008, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 5'd0, 32'd0);
    chk("loaduse_clear", stall, 1'b0);
    after_edge();
    chk("loaduse_issue", {nop_out, ex_rd}, {1'b0, 5'd2});

    step({6'h03, 26'h000_0040}, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    chk("jal_is_jump", control_is_jump, 1'b1);
    chk("jal_target", data_jump_address, 32'h0000_0100);
    after_edge();
    chk("jal_ex", {ex_rd, ex_link, ex_reg_write, ex_npc}, {5'd31, 1'b1, 1'b1, 32'h0040_0014});

    step(itype(6'h2B, 5'd1, 5'd2, 16'h0004), 32'h0040_0018, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    after_edge();
    chk("flush_sw", {ex_mem_write, nop_out}, {1'b0, 1'b1});
    step(rtype(5'd8, 5'd9, 5'd2, 6'h20), 32'h0040_001C, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
    after_edge();
    chk("flush_stall_bubble", nop_out, 1'b1);
    step(rtype(5'd5, 5'd9, 5'd7, 6'h22), 32'h0040_0020, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);

    idle(1'b1, 5'd4, 32'h1111_1111);
    step(rtype(5'd4, 5'd0, 5'd6, 6'h20), 32'h0040_0024, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hA5A5_A5A5);
    after_edge();
    chk("same_cycle_wb", ex_rs_data, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    step(rtype(5'd4, 5'd0, 5'd6, 6'h20), 32'h0040_0028, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);

    step(itype(6'h08, 5'd1, 5'd2, 16'h8001), 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    after_edge();
    chk("npc_wrap", ex_npc, 32'd0);

    for (int r = 1; r < 32; r++) idle(1'b1, 5'(r), $urandom | 32'h1);
    for (int n = 0; n < 150; n++) rand_step();

    do_reset();
    for (int r = 1; r < 32; r++)
      step(rtype(5'(r), 5'(r), 5'd1, 6'h20), 32'h0000_1000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    after_edge();
    chk("post_reset_r31", {ex_rs_data, ex_rt_data}, 64'd0);

    for (int n = 0; n < 250; n++) rand_step();

    @(posedge clock); #3;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_id.md
# stage_id

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. Takes the fetched instruction and its address, reads the 32×32 register file, decodes control, and detects load-use hazards. It drives `stall` back to fetch. It resolves `j`/`jal` in decode and drives the jump request and target to fetch. Results are captured in the ID/EX pipeline register, with a one-cycle latency.

## Interface
- No parameters.
- `clock`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears regfile and ID/EX register.
- `instruction`  in  32  fetched word, valid in the cycle after its address is issued.
- `iadd`  in  32  address of `instruction`.
- `nop_in`  in  1  fetch bubble marker; 1 means `instruction` is invalid.
- `flush`  in  1  wrong-path kill from branch resolution in EX.
- `ex_mem_read`  in  1  the instruction currently in EX is `lw`.
- `ex_rt`  in  5  destination register of that `lw`.
- `wb_reg_write`  in  1  writeback enable.
- `wb_write_reg`  in  5  writeback register index.
- `wb_write_data`  in  32  writeback value.
- `stall`  out  1  combinational; freezes PC and fetch.
- `control_is_jump`  out  1  combinational; `j`/`jal` valid in ID and not stalled.
- `data_jump_address`  out  32  `{iadd[31:28], instruction[25:0], 2'b00}`.
- `ex_rs_data`, `ex_rt_data`  out  32 each  registered operand values.
- `ex_imm`  out  32  sign-extended immediate; zero-extended for `andi`/`ori`; `{imm,16'b0}` for `lui`.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  registered register indices; `ex_rd` is forced to 31 for `jal`.
- `ex_funct`  out  6  R-type funct field; `ex_opcode`  out  6.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_alu_src`, `ex_reg_dst`, `ex_branch_eq`, `ex_branch_ne`, `ex_link`  out  1 each  registered control signals.
- `ex_npc`  out  32  `iadd + 4`, registered.
- `nop_out`  out  1  registered bubble marker for EX.

## Operation
- Decoded subset:
  - R-type: `add`, `sub`, `and`, `or`, `slt`, `sll`, `srl`, `jr`.
  - I-type: `addi`, `andi`, `ori`, `slti`, `lui`, `lw`, `sw`, `beq`, `bne`.
  - J-type: `j`, `jal`.
  - Any other opcode decodes as a bubble: all control signals 0, `nop_out`=1.
- Register file:
  - 32×32 storage; register 0 reads 0 always and ignores writes.
  - Writes occur on the rising edge when `wb_reg_write`=1.
  - Reads are combinational, by `instruction[25:21]` and `instruction[20:16]`.
- Load-use hazard: `stall` = `ex_mem_read` & `~nop_in` & (`ex_rt`≠0) & (`ex_rt`==rs | (`ex_rt`==rt & the instruction reads rt)).
  - rt is read by R-type, `beq`, `bne`, and `sw`.
- On stall, the ID/EX register loads a bubble: all control signals 0, `nop_out`=1. The other ID/EX fields hold their previous values.
- On `flush`, or when `nop_in`=1, the ID/EX register loads a bubble.
- Priority, highest first: reset, then `flush`, then `stall`, then normal capture.
- `control_is_jump` = decoded `j`/`jal` & `~nop_in` & `~flush` & `~stall`.
- `jal` passes to EX with `ex_link`=1, `ex_reg_write`=1, `ex_rd`=31. The value to write comes from `ex_npc`.

## Timing
- Reset, asynchronous: every `ex_*` output is 0, `nop_out`=1, and all 32 registers are 0. `stall` and `control_is_jump` follow their combinational definitions with the reset state.
- Latency: decode outputs appear on the `ex_*` outputs one clock after the instruction is present at the input.
- `stall` is combinational. It is asserted within the same cycle and held for exactly one cycle per load-use hazard. On the next edge the `lw` leaves EX and the hazard clears.
- `control_is_jump` and `data_jump_address` are combinational. Fetch redirects on the following edge.
- WB write and ID read of the same register in the same cycle: the result depends on `REGFILE_BYPASS_EN` (see Configuration).
- `ex_npc` wraps modulo 2^32; `iadd`=0xFFFFFFFC gives `ex_npc`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined: if `wb_reg_write` & `wb_write_reg`≠0 & (`wb_write_reg`==rs or ==rt), that operand read returns `wb_write_data` in the same cycle (write-before-read).
- `REGFILE_BYPASS_EN` undefined: the read returns the old register contents. Software must separate a dependent instruction from its writeback by at least one instruction.

## Test plan
- Reset asserted mid-run with regfile populated → all registers read 0, `nop_out`=1, `ex_reg_write`=0. This must hold immediately, without waiting for a clock edge.
- WB writes 0x1234_5678 to r5 → a later `add r3,r5,r0` gives `ex_rs_data`=0x12345678 and `ex_rd`=3 one cycle later. A write of 0xFFFFFFFF to r0 leaves r0 reading 0.
- `lw r8,0(r1)` in EX (`ex_mem_read`=1, `ex_rt`=8) with `add r2,r8,r9` in ID → `stall`=1 for one cycle and a bubble (`nop_out`=1) enters EX. The add issues on the next cycle.
- `jal 0x0000040` at `iadd`=0x0040_0010 → `control_is_jump`=1, `data_jump_address`=0x0000_0100. Next cycle: `ex_rd`=31, `ex_link`=1, `ex_npc`=0x0040_0014.
- `flush`=1 with `sw` in ID → `ex_mem_write`=0 and `nop_out`=1. `flush` and `stall` together → bubble, no stall-held state corruption.
- Same-cycle WB to r4=0xA5A5A5A5 and an ID read of r4 → `ex_rs_data`=0xA5A5A5A5 with `REGFILE_BYPASS_EN`; the old value without it.
